// File: rtl/cmp_match_detector.sv
// Compares the upstream counter value against a reference latched at arm time and
// counts matches. Optional macro CMP_SEQ_CHECK_EN adds a sticky increment-by-one check (seq_err).
module cmp_match_detector #(
    parameter int W      = 2,
    parameter int HOLD   = 1,
    parameter int TARGET = 4,
    parameter int CW     = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W-1:0]  cnt_in,
    input  logic [W-1:0]  ref_val,
    input  logic          arm,
    input  logic          en,
    input  logic          clr,
    output logic          eq_o,
    output logic          gt_o,
    output logic          lt_o,
    output logic          match_pulse,
    output logic [CW-1:0] match_count,
    output logic          done,
    output logic          busy
`ifdef CMP_SEQ_CHECK_EN
   ,output logic          seq_err
`endif
);

    // state   | meaning
    // IDLE    | waiting for arm
    // ARMED   | counting consecutive equal samples toward a match
    // MATCHED | match recorded, waiting for the sample to leave ref_q
    // DONE    | TARGET matches seen, held until clr or reset
    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_MATCHED, S_DONE} state_t;

    localparam int HW = $clog2(HOLD + 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD - 1);
    localparam logic [CW-1:0] CNT_MAX    = '1;
    localparam logic [CW-1:0] TARGET_CNT = CW'(TARGET);

    state_t        state_q, state_d;
    logic [W-1:0]  ref_q, ref_d;
    logic [W-1:0]  samp_q, samp_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [CW-1:0] count_q, count_d, count_inc;
    logic          eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;
    logic          pulse_q, pulse_d, done_q, done_d, busy_q, busy_d;
    logic          samp_eq;

    // The FSM works on the registered sample, giving the two-edge match latency.
    assign samp_eq = (samp_q == ref_q);

    always_comb begin
        state_d   = state_q;
        ref_d     = ref_q;
        hold_d    = hold_q;
        count_d   = count_q;
        samp_d    = cnt_in;
        eq_d      = (cnt_in == ref_q);
        gt_d      = (cnt_in > ref_q);
        lt_d      = (cnt_in < ref_q);
        pulse_d   = 1'b0;
        count_inc = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;
        if (clr) begin
            state_d = S_IDLE;
            hold_d  = '0;
            count_d = '0;
        end else if (en) begin
            case (state_q)
                S_IDLE: begin
                    if (arm) begin
                        ref_d   = ref_val;
                        hold_d  = '0;
                        count_d = '0;
                        state_d = S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (samp_eq) begin
                        if (hold_q == HOLD_LAST) begin
                            pulse_d = 1'b1;
                            hold_d  = '0;
                            count_d = count_inc;
                            state_d = (count_inc == TARGET_CNT) ? S_DONE : S_MATCHED;
                        end else begin
                            hold_d = hold_q + 1'b1;
                        end
                    end else begin
                        hold_d = '0;
                    end
                end
                S_MATCHED: begin
                    if (!samp_eq) state_d = S_ARMED;
                end
                S_DONE:  state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
        done_d = (state_d == S_DONE);
        busy_d = (state_d == S_ARMED) || (state_d == S_MATCHED);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ref_q   <= '0;
            samp_q  <= '0;
            hold_q  <= '0;
            count_q <= '0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            pulse_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ref_q   <= ref_d;
            samp_q  <= samp_d;
            hold_q  <= hold_d;
            count_q <= count_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            pulse_q <= pulse_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign eq_o        = eq_q;
    assign gt_o        = gt_q;
    assign lt_o        = lt_q;
    assign match_pulse = pulse_q;
    assign match_count = count_q;
    assign done        = done_q;
    assign busy        = busy_q;

`ifdef CMP_SEQ_CHECK_EN
    logic [W-1:0] prev_q, prev_d;
    logic         seq_vld_q, seq_vld_d, seq_err_q, seq_err_d;

    // The first sample after reset or clr only primes prev_q.
    always_comb begin
        prev_d    = cnt_in;
        seq_vld_d = 1'b1;
        seq_err_d = seq_err_q;
        if (clr) begin
            seq_vld_d = 1'b0;
            seq_err_d = 1'b0;
        end else if (seq_vld_q && (cnt_in != W'(prev_q + 1'b1))) begin
            seq_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_q    <= '0;
            seq_vld_q <= 1'b0;
            seq_err_q <= 1'b0;
        end else begin
            prev_q    <= prev_d;
            seq_vld_q <= seq_vld_d;
            seq_err_q <= seq_err_d;
        end
    end

    assign seq_err = seq_err_q;
`endif

endmodule
